neuron_stream: RTL
==================

# neuron_stream

Streaming, parametrised neuron. It consumes one (input, weight) pair per handshake and accumulates a frame of up to N_INPUTS products. It then adds a bias, applies a runtime-selectable activation, saturates to OUT_W and holds the result on a valid/ready output. It replaces the fixed three-stage single-input neuron in layer datapaths. It is the building block for multi-input layers fed by a weight/activation sequencer.

## Interface
- DATA_W, 8: signed width of x, w and bias.
- N_INPUTS, 4: maximum fan-in (products per frame); must be ≥1.
- OUT_W, 16: signed output width; result saturates to this range.
- Derived ACC_W = 2*DATA_W + $clog2(N_INPUTS) + 1: accumulator and bias-sum width, never overflows internally.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  x/w/in_last/bias/act_mode valid.
- in_ready  out  1  block accepts a beat this cycle.
- x  in  DATA_W  signed input activation.
- w  in  DATA_W  signed weight.
- in_last  in  1  final beat of frame.
- bias  in  DATA_W  signed bias; sampled on the beat that ends the frame.
- act_mode  in  2  00 identity, 01 ReLU, 10 clip [0, 2^(DATA_W-1)-1], 11 leaky (negative >>> 3). Sampled on the first beat of a frame.
- y_valid  out  1  result available.
- y_ready  in  1  downstream accepts result.
- y  out  OUT_W  signed activated, saturated result.
- y_sat  out  1  OUT_W saturation occurred for this result; qualified by y_valid.
- y_frame_err  out  1  frame ended by count reaching N_INPUTS without in_last; qualified by y_valid.

## Operation
- States: ACCUM, BIAS, ACT, OUT.
- ACCUM: in_ready=1. A beat is accepted when in_valid & in_ready.
  - Each accepted beat does acc <= acc + sext(x*w) and cnt <= cnt+1.
  - On the first beat of a frame (cnt==0), acc loads the product directly (no stale add) and act_mode is latched.
- A frame ends on the accepted beat with in_last=1, or on the beat where cnt==N_INPUTS-1.
  - If the count ends the frame and in_last=0, the err flag is latched.
  - On frame end, bias is latched and the state goes to BIAS.
  - Early in_last (frame shorter than N_INPUTS) is legal and is not an error.
- BIAS: sum <= acc + sext(bias_l) at ACC_W, then go to ACT. in_ready=0.
- ACT: apply act_mode to sum.
  - ReLU: negative → 0.
  - Clip: clamp to [0, 2^(DATA_W-1)-1].
  - Leaky: negative values arithmetic-shifted right by 3 (floor); non-negative values pass.
  - Then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and set y_sat if clamping occurred here. Clip-mode clamping does not set y_sat.
  - Register y, y_sat, y_frame_err; set y_valid=1; go to OUT.
- OUT: y, y_sat and y_frame_err are held stable while y_valid=1 & y_ready=0.
  - On y_valid & y_ready, clear y_valid, acc, cnt and err; go to ACCUM.
- in_ready=0 in BIAS, ACT and OUT. The block processes one frame at a time and accepts no new beats while a result is pending.
- rst (any state, including mid-frame or while OUT is stalled) → ACCUM, cnt=0, acc=0, y_valid=0, y=0, y_sat=0, y_frame_err=0. Reset state has in_ready=1. A partial frame is discarded.

## Timing
- Beat accepted at edge t → acc reflects it after edge t.
- Frame-ending beat at edge t0 → BIAS during t0..t0+1, ACT after edge t0+1, y_valid=1 after edge t0+2.
- Latency from last beat to y_valid is 2 cycles.
- With y_ready held high, y_valid lasts exactly 1 cycle, and in_ready returns the cycle after the output handshake.
- Peak throughput is N beats per N+3 cycles.
- in_valid is ignored when in_ready=0; x, w and bias may change freely outside accepted beats.
- y_ready while y_valid=0 has no effect.
- rst asserted in the same cycle as a beat or output handshake: reset wins and the beat or handshake is lost.

## Test plan
- Identity frame x=[1,2,3,4], w=[5,6,7,8], bias=-10, act 00, in_last on beat 4, y_ready=1 → y=60 two cycles after the last beat; y_sat=0, y_frame_err=0.
- ReLU/leaky: x=[-10], w=[6], in_last=1, bias=0 → act 01 gives y=0; act 11 gives y=-8 (−60>>>3).
- Clip and saturation:
  - x=[-128]×4, w=[-128]×4, bias=127, act 00 → y=32767, y_sat=1.
  - Same frame with act 10 → y=127, y_sat=0.
- Frame error: 4 beats without in_last, values as in the identity frame → y=70 (bias 0), y_frame_err=1. A following 2-beat frame with in_last on beat 2 → y_frame_err=0.
- Backpressure: y_ready=0 for 5 cycles after y_valid → y stable, in_ready=0, in_valid beats ignored. Release y_ready → one handshake, then in_ready=1 the next cycle.
- Reset mid-operation:
  - rst after 2 of 4 beats → y_valid never asserts for that frame, and the next full frame computes from zero.
  - rst while OUT is stalled → y_valid=0, y=0 the cycle after the reset edge.

Source files
------------

// File: rtl/neuron_stream.sv
// rtl/neuron_stream.sv - streaming multiply-accumulate neuron with bias, selectable activation and output saturation
module neuron_stream #(
   parameter int DATA_W   = 8,
   parameter int N_INPUTS = 4,
   parameter int OUT_W    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] x,
   input  logic signed [DATA_W-1:0] w,
   input  logic                     in_last,
   input  logic signed [DATA_W-1:0] bias,
   input  logic [1:0]               act_mode,
   output logic                     y_valid,
   input  logic                     y_ready,
   output logic signed [OUT_W-1:0]  y,
   output logic                     y_sat,
   output logic                     y_frame_err
);

   // Accumulator is sized so N_INPUTS worst-case products plus a bias cannot overflow.
   localparam int ACC_W = 2*DATA_W + $clog2(N_INPUTS) + 1;
   localparam int CNT_W = $clog2(N_INPUTS + 1);
   // One guard bit above the wider of accumulator/output keeps the saturation compare exact.
   localparam int SAT_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);
   localparam logic signed [ACC_W-1:0] CLIP_MAX =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [SAT_W-1:0] OUT_MAX =
      {{(SAT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [SAT_W-1:0] OUT_MIN =
      {{(SAT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   localparam logic [1:0] MODE_RELU  = 2'b01;
   localparam logic [1:0] MODE_CLIP  = 2'b10;
   localparam logic [1:0] MODE_LEAKY = 2'b11;

   typedef enum logic [1:0] {ACCUM, BIAS, ACT, OUT} state_t;

   state_t                    state_q, state_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      err_q, err_d;
   logic [1:0]                mode_q, mode_d;
   logic signed [DATA_W-1:0]  bias_q, bias_d;
   logic signed [ACC_W-1:0]   sum_q, sum_d;
   logic signed [OUT_W-1:0]   y_q, y_d;
   logic                      y_valid_q, y_valid_d;
   logic                      y_sat_q, y_sat_d;
   logic                      y_err_q, y_err_d;

   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W-1:0]    bias_ext;
   logic signed [ACC_W-1:0]    act_val;
   logic signed [SAT_W-1:0]    act_wide;
   logic signed [OUT_W-1:0]    sat_val;
   logic                       sat_flag;

   // Operands are sign-extended to full product width so the low bits form the signed product.
   assign prod     = {{DATA_W{x[DATA_W-1]}}, x} * {{DATA_W{w[DATA_W-1]}}, w};
   assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
   assign bias_ext = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q};

   assign in_ready    = (state_q == ACCUM);
   assign y_valid     = y_valid_q;
   assign y           = y_q;
   assign y_sat       = y_sat_q;
   assign y_frame_err = y_err_q;

   // Activation on the biased sum, using the mode latched at the start of the frame.
   always_comb begin
      act_val = sum_q;
      case (mode_q)
         MODE_RELU: begin
            if (sum_q[ACC_W-1]) act_val = '0;
         end
         MODE_CLIP: begin
            if (sum_q[ACC_W-1])       act_val = '0;
            else if (sum_q > CLIP_MAX) act_val = CLIP_MAX;
         end
         MODE_LEAKY: begin
            if (sum_q[ACC_W-1]) act_val = sum_q >>> 3;
         end
         default: act_val = sum_q;
      endcase
   end

   // Clamp the activated value into the output range; only this clamp raises y_sat.
   always_comb begin
      act_wide = {{(SAT_W-ACC_W){act_val[ACC_W-1]}}, act_val};
      sat_flag = 1'b0;
      sat_val  = act_wide[OUT_W-1:0];
      if (act_wide > OUT_MAX) begin
         sat_val  = OUT_MAX[OUT_W-1:0];
         sat_flag = 1'b1;
      end else if (act_wide < OUT_MIN) begin
         sat_val  = OUT_MIN[OUT_W-1:0];
         sat_flag = 1'b1;
      end
   end

   // Frame sequencing: accumulate beats, add bias, activate, then hold the result until taken.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      mode_d    = mode_q;
      bias_d    = bias_q;
      sum_d     = sum_q;
      y_d       = y_q;
      y_valid_d = y_valid_q;
      y_sat_d   = y_sat_q;
      y_err_d   = y_err_q;
      case (state_q)
         ACCUM: begin
            if (in_valid) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == '0) begin
                  acc_d  = prod_ext;
                  mode_d = act_mode;
               end else begin
                  acc_d = acc_q + prod_ext;
               end
               if (in_last || (cnt_q == LAST_CNT)) begin
                  bias_d  = bias;
                  err_d   = !in_last;
                  state_d = BIAS;
               end
            end
         end
         BIAS: begin
            sum_d   = acc_q + bias_ext;
            state_d = ACT;
         end
         ACT: begin
            y_d       = sat_val;
            y_sat_d   = sat_flag;
            y_err_d   = err_q;
            y_valid_d = 1'b1;
            state_d   = OUT;
         end
         OUT: begin
            if (y_ready) begin
               y_valid_d = 1'b0;
               acc_d     = '0;
               cnt_d     = '0;
               err_d     = 1'b0;
               state_d   = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   // State register; reset discards any partial frame or pending result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ACCUM;
         acc_q     <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         mode_q    <= '0;
         bias_q    <= '0;
         sum_q     <= '0;
         y_q       <= '0;
         y_valid_q <= 1'b0;
         y_sat_q   <= 1'b0;
         y_err_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         mode_q    <= mode_d;
         bias_q    <= bias_d;
         sum_q     <= sum_d;
         y_q       <= y_d;
         y_valid_q <= y_valid_d;
         y_sat_q   <= y_sat_d;
         y_err_q   <= y_err_d;
      end
   end

endmodule
